// File: rtl/gate_test_pkg.sv
// Shared definitions for the 2-input gate exerciser: FSM states,
// reference truth tables and the settle-counter width.
package gate_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Bit i is the gate output for a=i[1], b=i[0].
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  localparam int SETTLE_W = 4;

  function automatic logic tt_expected(input logic [3:0] tt, input logic [1:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate2_exerciser_if.sv
// Bundle of the exerciser's control, drive and result signals.
// master is the exerciser side, slave is the lab top / gate side.
interface gate2_exerciser_if;
  logic       start;
  logic       dut_out;
  logic       drv_a;
  logic       drv_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport master (
    input  start, dut_out,
    output drv_a, drv_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, dut_out,
    input  drv_a, drv_b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate2_exerciser_settle_counter.sv
// Loadable down-counter timing the settle wait; it stops at zero
// rather than wrapping.
module settle_counter
  import gate_test_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                dec,
  input  logic [SETTLE_W-1:0] load_value,
  output logic [SETTLE_W-1:0] value,
  output logic                zero
);

  logic [SETTLE_W-1:0] value_r;

  // Counter register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_r <= {SETTLE_W{1'b0}};
    end else if (load) begin
      value_r <= load_value;
    end else if (dec && (value_r != {SETTLE_W{1'b0}})) begin
      value_r <= value_r - {{(SETTLE_W-1){1'b0}}, 1'b1};
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign zero  = (value_r == {SETTLE_W{1'b0}});

endmodule

// File: rtl/gate2_exerciser.sv
// Walks all four input vectors through a 2-input gate, waits SETTLE_CYCLES
// per vector, compares the gate output with TRUTH_TABLE and reports results.
module gate2_exerciser
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] TRUTH_TABLE   = TT_NAND
)
(
  input  logic               clk,
  input  logic               rst_n,
  gate2_exerciser_if.master  bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  state_e              state_r, state_s;
  logic [1:0]          idx_r, idx_s;
  logic                drv_a_r, drv_a_s;
  logic                drv_b_r, drv_b_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                pass_r, pass_s;
  logic [2:0]          err_count_r, err_count_s;
  logic [3:0]          fail_vec_r, fail_vec_s;
  logic                cnt_load_s;
  logic                cnt_dec_s;
  logic                mismatch_s;
  logic [SETTLE_W-1:0] cnt_value_s;
  logic                cnt_zero_s;

  settle_counter u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load_s),
    .dec        (cnt_dec_s),
    .load_value (SETTLE_LOAD),
    .value      (cnt_value_s),
    .zero       (cnt_zero_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    drv_a_s     = drv_a_r;
    drv_b_s     = drv_b_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    pass_s      = pass_r;
    err_count_s = err_count_r;
    fail_vec_s  = fail_vec_r;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    mismatch_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s     = APPLY;
          idx_s       = 2'd0;
          drv_a_s     = 1'b0;
          drv_b_s     = 1'b0;
          busy_s      = 1'b1;
          pass_s      = 1'b0;
          err_count_s = 3'd0;
          fail_vec_s  = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end

      APPLY: begin
        cnt_load_s = 1'b1;
        if (SETTLE_CYCLES == 32'sd0) begin
          state_s = CHECK;
        end else begin
          state_s = WAIT;
        end
      end

      // Counter holds S..1 across the WAIT cycles; zero only guards a stuck count.
      WAIT: begin
        cnt_dec_s = 1'b1;
        if (cnt_zero_s || (cnt_value_s == {{(SETTLE_W-1){1'b0}}, 1'b1})) begin
          state_s = CHECK;
        end else begin
          state_s = WAIT;
        end
      end

      CHECK: begin
        mismatch_s = (bus.dut_out != tt_expected(TRUTH_TABLE, idx_r));
        if (mismatch_s) begin
          err_count_s        = err_count_r + 3'd1;
          fail_vec_s[idx_r]  = 1'b1;
        end else begin
          err_count_s = err_count_r;
          fail_vec_s  = fail_vec_r;
        end
        if (idx_r == 2'd3) begin
          state_s = DONE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          pass_s  = (err_count_s == 3'd0);
          drv_a_s = 1'b0;
          drv_b_s = 1'b0;
        end else begin
          state_s = APPLY;
          idx_s   = idx_r + 2'd1;
          drv_a_s = idx_s[1];
          drv_b_s = idx_s[0];
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
        idx_s   = 2'd0;
        drv_a_s = 1'b0;
        drv_b_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      drv_a_r     <= 1'b0;
      drv_b_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= 3'd0;
      fail_vec_r  <= 4'd0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      drv_a_r     <= drv_a_s;
      drv_b_r     <= drv_b_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      err_count_r <= err_count_s;
      fail_vec_r  <= fail_vec_s;
    end
  end

  assign bus.drv_a     = drv_a_r;
  assign bus.drv_b     = drv_b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_count_r;
  assign bus.fail_vec  = fail_vec_r;

endmodule

// File: tb/tb_gate2_exerciser.sv
// Bench: three exercisers (S=2/NAND, S=0/NAND, S=3/AND) each driving a
// modelled gate; a cycle-by-cycle reference derived from the run timing rules.
module tb_gate2_exerciser;
  import gate_test_pkg::*;

  logic clk;
  logic rst_n;
  logic [2:0]      start_i;
  logic [3:0]      gate_tt [3];
  logic [2:0]      busy_o, done_o, pass_o;
  logic [2:0][1:0] drv_o;
  logic [2:0][2:0] err_o;
  logic [2:0][3:0] fail_o;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int         S_G  = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    localparam logic [3:0] TT_G = (g == 2) ? TT_AND : TT_NAND;

    gate2_exerciser_if bif ();

    gate2_exerciser #(
      .SETTLE_CYCLES (S_G),
      .TRUTH_TABLE   (TT_G)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
    );

    assign bif.start   = start_i[g];
    assign bif.dut_out = gate_tt[g][{bif.drv_a, bif.drv_b}];
    assign busy_o[g]   = bif.busy;
    assign done_o[g]   = bif.done;
    assign pass_o[g]   = bif.pass;
    assign drv_o[g]    = {bif.drv_a, bif.drv_b};
    assign err_o[g]    = bif.err_count;
    assign fail_o[g]   = bif.fail_vec;
  end

  function automatic int s_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic logic [3:0] tt_of(input int k);
    return (k == 2) ? 4'b1000 : 4'b0111;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    check($sformatf("%s_u%0d_drv", tag, k),  8'(drv_o[k]),  8'd0);
    check($sformatf("%s_u%0d_busy", tag, k), 8'(busy_o[k]), 8'd0);
    check($sformatf("%s_u%0d_done", tag, k), 8'(done_o[k]), 8'd0);
    check($sformatf("%s_u%0d_pass", tag, k), 8'(pass_o[k]), 8'd0);
    check($sformatf("%s_u%0d_err", tag, k),  8'(err_o[k]),  8'd0);
    check($sformatf("%s_u%0d_fail", tag, k), 8'(fail_o[k]), 8'd0);
  endtask

  // One full run on instance k with gate truth table 'gate'; optional
  // ignored start pulses at edge E0+5 and during DONE.
  task automatic do_run(input int k, input logic [3:0] gate, input bit repulse);
    int s, per, len, nv;
    logic [3:0] exp_tt, exp_fail;
    logic [2:0] exp_err;
    logic [1:0] exp_drv;
    logic       exp_busy, exp_done, exp_pass;
    s      = s_of(k);
    per    = s + 2;
    len    = 4 * per;
    exp_tt = tt_of(k);
    gate_tt[k] = gate;
    @(negedge clk);
    start_i[k] = 1'b1;
    @(negedge clk);
    start_i[k] = 1'b0;
    for (int t = 0; t <= len + 1; t++) begin
      nv = t / per;
      if (nv > 4) nv = 4;
      exp_err  = 3'd0;
      exp_fail = 4'd0;
      for (int v = 0; v < nv; v++) begin
        if (gate[v] != exp_tt[v]) begin
          exp_err     = exp_err + 3'd1;
          exp_fail[v] = 1'b1;
        end
      end
      if (t < len) begin
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_drv  = 2'(t / per);
        exp_pass = 1'b0;
      end else begin
        exp_busy = 1'b0;
        exp_done = (t == len);
        exp_drv  = 2'd0;
        exp_pass = (gate == exp_tt);
      end
      check($sformatf("u%0d_t%0d_drv", k, t),  8'(drv_o[k]),  8'(exp_drv));
      check($sformatf("u%0d_t%0d_busy", k, t), 8'(busy_o[k]), 8'(exp_busy));
      check($sformatf("u%0d_t%0d_done", k, t), 8'(done_o[k]), 8'(exp_done));
      check($sformatf("u%0d_t%0d_pass", k, t), 8'(pass_o[k]), 8'(exp_pass));
      check($sformatf("u%0d_t%0d_err", k, t),  8'(err_o[k]),  8'(exp_err));
      check($sformatf("u%0d_t%0d_fail", k, t), 8'(fail_o[k]), 8'(exp_fail));
      start_i[k] = repulse && ((t == 4) || (t == len));
      @(negedge clk);
    end
    start_i[k] = 1'b0;
  endtask

  // Run aborted by a one-edge reset at E0+7; no done may follow.
  task automatic do_reset_run(input int k, input logic [3:0] gate);
    int len;
    len = 4 * (s_of(k) + 2);
    gate_tt[k] = gate;
    @(negedge clk);
    start_i[k] = 1'b1;
    @(negedge clk);
    start_i[k] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      check($sformatf("rst_u%0d_t%0d_busy", k, t), 8'(busy_o[k]), 8'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) check_zero(j, "rst_abort");
    for (int t = 0; t < len + 4; t++) begin
      @(negedge clk);
      check($sformatf("rst_u%0d_c%0d_done", k, t), 8'(done_o[k]), 8'd0);
      check($sformatf("rst_u%0d_c%0d_busy", k, t), 8'(busy_o[k]), 8'd0);
    end
  endtask

  initial begin
    int k;
    logic [3:0] g;
    bit rep;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    start_i = 3'b000;
    for (int j = 0; j < 3; j++) gate_tt[j] = 4'b0000;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) check_zero(j, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_run(0, TT_NAND, 1'b0);   // correct nand_21, S=2
    do_run(0, 4'b1111, 1'b0);   // dut_out tied high
    do_run(0, TT_AND,  1'b0);   // and_21 against NAND table
    do_run(2, TT_AND,  1'b0);   // and_21 against AND table, S=3
    do_run(1, TT_NAND, 1'b0);   // S=0
    do_run(0, TT_NAND, 1'b1);   // ignored start re-pulses
    do_reset_run(0, TT_NAND);
    do_run(0, 4'b1111, 1'b1);   // rerun after abort, results cleared

    for (int r = 0; r < 10; r++) begin
      k   = int'($urandom_range(0, 2));
      g   = 4'($urandom_range(0, 15));
      rep = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(k, g, rep);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
